alu_seq: RTL and testbench

Multi-cycle integer execution unit that consumes the 4-bit `alu_op` encoding produced by the ALU-op decoder and returns a registered result. It sits in the execute stage, between the operand-select muxes and the writeback/branch logic. A valid/ready handshake on both sides lets a multi-cycle core stall on it. Shifts run iteratively at one bit per cycle by default.

---
 rtl/alu_seq.sv | 175 +++++++++++++++++
 tb/tb_alu_seq.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - multi-cycle integer ALU with iterative shifter (ALU_SEQ_FAST_SHIFT_EN selects a barrel shifter)
module alu_seq #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      alu_op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero
);

    localparam int SHW = $clog2(XLEN);

`ifdef ALU_SEQ_FAST_SHIFT_EN
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DONE = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;
`endif

    state_t          state;
    state_t          state_next;
    logic [SHW-1:0]  shamt;
    logic [XLEN-1:0] eval_res;

    assign shamt = b[SHW-1:0];

    // Single-cycle evaluation; shifts use a barrel shifter, which for
    // shamt=0 degenerates to passing a through in the iterative build.
    function automatic logic [XLEN-1:0] alu_eval(
        input logic [3:0]      op,
        input logic [XLEN-1:0] x,
        input logic [XLEN-1:0] y,
        input logic [SHW-1:0]  sh
    );
        logic [XLEN-1:0] r;
        case (op)
            4'b0000: r = x + y;
            4'b0001: r = x - y;
            4'b0010: r = {{(XLEN-1){1'b0}}, ($signed(x) < $signed(y))};
            4'b0011: r = {{(XLEN-1){1'b0}}, (x < y)};
            4'b0100: r = x & y;
            4'b0101: r = x | y;
            4'b0110: r = x ^ y;
            4'b1000: r = x << sh;
            4'b1001: r = x >> sh;
            4'b1011: r = $signed(x) >>> sh;
            default: r = x + y;
        endcase
        return r;
    endfunction

    assign eval_res = alu_eval(alu_op, a, b, shamt);

`ifndef ALU_SEQ_FAST_SHIFT_EN
    logic            is_shift;
    logic [1:0]      sop;
    logic [XLEN-1:0] work;
    logic [XLEN-1:0] work_next;
    logic [SHW-1:0]  cnt;

    assign is_shift = (alu_op == 4'b1000) || (alu_op == 4'b1001) || (alu_op == 4'b1011);

    // One-bit shift step of the working register, kind chosen by op[1:0].
    always_comb begin
        work_next = work;
        case (sop)
            2'b00:   work_next = {work[XLEN-2:0], 1'b0};
            2'b01:   work_next = {1'b0, work[XLEN-1:1]};
            2'b11:   work_next = {work[XLEN-1], work[XLEN-1:1]};
            default: work_next = work;
        endcase
    end
`endif

    // State register; reset discards any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake outputs; outputs depend on state only.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
`ifdef ALU_SEQ_FAST_SHIFT_EN
                    state_next = DONE;
`else
                    state_next = (is_shift && (shamt != '0)) ? SHIFT : DONE;
`endif
                end
            end
`ifndef ALU_SEQ_FAST_SHIFT_EN
            SHIFT: begin
                if (cnt == SHW'(1)) begin
                    state_next = DONE;
                end
            end
`endif
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath: latch the result on accept, or run the iterative shifter.
    always_ff @(posedge clk) begin
        if (rst) begin
            result <= '0;
            zero   <= 1'b0;
`ifndef ALU_SEQ_FAST_SHIFT_EN
            work   <= '0;
            cnt    <= '0;
            sop    <= 2'b00;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
`ifdef ALU_SEQ_FAST_SHIFT_EN
                        result <= eval_res;
                        zero   <= (eval_res == '0);
`else
                        if (is_shift && (shamt != '0)) begin
                            work <= a;
                            cnt  <= shamt;
                            sop  <= alu_op[1:0];
                        end else begin
                            result <= eval_res;
                            zero   <= (eval_res == '0);
                        end
`endif
                    end
                end
`ifndef ALU_SEQ_FAST_SHIFT_EN
                SHIFT: begin
                    work <= work_next;
                    cnt  <= cnt - SHW'(1);
                    if (cnt == SHW'(1)) begin
                        result <= work_next;
                        zero   <= (work_next == '0);
                    end
                end
`endif
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - self-checking bench for alu_seq against a behavioural model
module tb_alu_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  alu_op = 4'd0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic        zero;

    int n_checks = 0;
    int n_fail   = 0;

    alu_seq #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .alu_op(alu_op), .a(a), .b(b), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .zero(zero)
    );

    always #5 clk = ~clk;

    // Reference result from the operation table.
    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
        int     sx, sy;
        int     sh;
        longint sum;
        sx  = x;
        sy  = y;
        sh  = int'(y % 32);
        sum = longint'(x) + longint'(y);
        case (op)
            4'd1:    return 32'(longint'(x) - longint'(y));
            4'd2:    return (sx < sy) ? 32'd1 : 32'd0;
            4'd3:    return (x < y) ? 32'd1 : 32'd0;
            4'd4:    return x & y;
            4'd5:    return x | y;
            4'd6:    return x ^ y;
            4'd8:    return 32'(longint'(x) * (longint'(1) << sh));
            4'd9:    return 32'(longint'(x) / (longint'(1) << sh));
            4'd11:   return 32'(sx >>> sh);
            default: return 32'(sum);
        endcase
    endfunction

    function automatic int ref_lat(input logic [3:0] op, input logic [31:0] y);
`ifdef ALU_SEQ_FAST_SHIFT_EN
        return 1;
`else
        if ((op == 4'd8 || op == 4'd9 || op == 4'd11) && (y % 32) != 0)
            return int'(y % 32) + 1;
        return 1;
`endif
    endfunction

    // Drives one request from IDLE, waits for out_valid (bounded), hands off.
    task automatic run_op(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                          output logic [31:0] res, output logic zr, output int lat);
        alu_op   = op;
        a        = x;
        b        = y;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        res = result;
        zr  = zero;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hs: in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
        end
        n_checks++;
        if (result !== 32'd0 || zero !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_regs: result=%h zero=%b required 0/0", result, zero);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_idle: in_ready=%b required 1", in_ready);
        end
    endtask

    task automatic test_directed;
        logic [3:0]  ops [8]  = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd7, 4'd11, 4'd9, 4'd8};
        logic [31:0] xs  [8]  = '{32'd7, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd3, 32'h80000000, 32'h80000000, 32'd1};
        logic [31:0] ys  [8]  = '{32'd5, 32'd5, 32'd1, 32'd1, 32'd4, 32'd31, 32'h25, 32'd0};
        logic [31:0] rs  [8]  = '{32'd12, 32'd0, 32'd1, 32'd0, 32'd7, 32'hFFFFFFFF, 32'h04000000, 32'd1};
        logic [31:0] res;
        logic        zr;
        int          lat;
        int          exp_lat;
        for (int i = 0; i < 8; i++) begin
            run_op(ops[i], xs[i], ys[i], res, zr, lat);
            exp_lat = ref_lat(ops[i], ys[i]);
            n_checks++;
            if (res !== rs[i] || zr !== (rs[i] == 32'd0)) begin
                n_fail++;
                $display("FAIL directed_%0d op=%h: result=%h zero=%b required %h/%b", i, ops[i], res, zr, rs[i], rs[i] == 32'd0);
            end
            n_checks++;
            if (lat !== exp_lat) begin
                n_fail++;
                $display("FAIL directed_lat_%0d op=%h: latency=%0d required %0d", i, ops[i], lat, exp_lat);
            end
        end
    endtask

    task automatic test_random;
        logic [31:0] res, x, y, exp;
        logic [3:0]  op;
        logic        zr;
        int          lat;
        for (int i = 0; i < 40; i++) begin
            op = 4'($urandom_range(0, 15));
            x  = $urandom;
            y  = $urandom;
            if (i % 5 == 0) y = x;
            run_op(op, x, y, res, zr, lat);
            exp = ref_alu(op, x, y);
            n_checks++;
            if (res !== exp || zr !== (exp == 32'd0) || lat !== ref_lat(op, y)) begin
                n_fail++;
                $display("FAIL random_%0d op=%h a=%h b=%h: result=%h zero=%b lat=%0d required %h/%b/%0d",
                         i, op, x, y, res, zr, lat, exp, exp == 32'd0, ref_lat(op, y));
            end
        end
    endtask

    task automatic test_backpressure;
        int lat;
        alu_op = 4'd6; a = 32'hF0F0; b = 32'hFFFF; in_valid = 1'b1;
        @(posedge clk); #1;
        alu_op = 4'd0; a = 32'd100; b = 32'd23;
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== 32'h0F0F) begin
                n_fail++;
                $display("FAIL bp_hold_%0d: out_valid=%b in_ready=%b result=%h required 1/0/0f0f", i, out_valid, in_ready, result);
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 32'h0F0F) begin
            n_fail++;
            $display("FAIL bp_handoff: in_ready=%b out_valid=%b result=%h required 1/0/0f0f", in_ready, out_valid, result);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b1 || result !== 32'd123) begin
            n_fail++;
            $display("FAIL bp_next_add: out_valid=%b result=%0d required 1/123", out_valid, result);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid;
        logic [31:0] res;
        logic        zr;
        int          lat;
        int          seen;
        alu_op = 4'd8; a = 32'd1; b = 32'd20; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 9; i++) begin
            if (out_valid) seen++;
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_idle: in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
        end
        for (int i = 0; i < 25; i++) begin
            if (out_valid) seen++;
            @(posedge clk); #1;
        end
        out_ready = 1'b0;
        n_checks++;
        if (seen !== 0) begin
            n_fail++;
            $display("FAIL rstmid_novalid: out_valid cycles=%0d required 0", seen);
        end
        run_op(4'd0, 32'd2, 32'd2, res, zr, lat);
        n_checks++;
        if (res !== 32'd4 || lat !== 1) begin
            n_fail++;
            $display("FAIL rstmid_add: result=%0d lat=%0d required 4/1", res, lat);
        end
    endtask

    task automatic test_back_to_back;
        int highs;
        int bad;
        alu_op = 4'd0; a = 32'd10; b = 32'd1;
        in_valid = 1'b1; out_ready = 1'b1;
        highs = 0; bad = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (out_valid) begin
                highs++;
                if (result !== 32'd11) bad++;
            end
        end
        in_valid = 1'b0;
        n_checks++;
        if (highs !== 4 || bad !== 0) begin
            n_fail++;
            $display("FAIL b2b: valid cycles=%0d bad results=%0d required 4/0", highs, bad);
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_idle: in_ready=%b required 1", in_ready);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
